// File: rtl/alu_result_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_stage_if
// Description : Upstream (ALU) and downstream (writeback) valid/ready bundle
//               used by the ALU result stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_result_stage_if #(
    parameter int N     = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_result;
    logic [2:0]       in_op;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_result;
    logic [2:0]       out_op;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;
    logic             out_neg;

    // Environment side: drives ALU results in, consumes writeback entries.
    modport master (
        output in_valid, in_result, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_op, out_tag, out_zero, out_neg
    );

    // Stage side.
    modport slave (
        input  in_valid, in_result, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_op, out_tag, out_zero, out_neg
    );
endinterface
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_stage
// Description : Registered ALU writeback stage: captures result/op/tag, derives
//               zero/neg flags at push time and buffers entries in a DEPTH-entry
//               FIFO presented over valid/ready. Optional performance counters
//               are enabled with `define ALU_RESULT_STAGE_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_stage #(
    parameter int N     = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               flush,
    alu_result_stage_if.slave       bus
`ifdef ALU_RESULT_STAGE_PERF_EN
    ,
    output logic [31:0]             perf_accepted,
    output logic [31:0]             perf_stall
`endif
);

    localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_EMPTY = '0;

    // ------------------------------------------------------------------
    // Storage and control state
    // ------------------------------------------------------------------
    logic [N-1:0]       r_mem_result [DEPTH];
    logic [2:0]         r_mem_op     [DEPTH];
    logic [TAG_W-1:0]   r_mem_tag    [DEPTH];
    logic               r_mem_zero   [DEPTH];
    logic               r_mem_neg    [DEPTH];

    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_push;
    logic               w_pop;
    logic               w_flag_zero;
    logic               w_flag_neg;

    // Ready depends only on registered occupancy, never on out_ready.
    assign w_in_ready  = (r_count != c_FULL);
    assign w_out_valid = (r_count != c_EMPTY);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;

    assign w_flag_zero = (bus.in_result == '0);
    assign w_flag_neg  = bus.in_result[N-1];

    // ------------------------------------------------------------------
    // Pointer / occupancy update; reset and flush both empty the FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload array needs no reset: outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_result[r_wptr] <= bus.in_result;
            r_mem_op[r_wptr]     <= bus.in_op;
            r_mem_tag[r_wptr]    <= bus.in_tag;
            r_mem_zero[r_wptr]   <= w_flag_zero;
            r_mem_neg[r_wptr]    <= w_flag_neg;
        end
    end

    // ------------------------------------------------------------------
    // Head presentation
    // ------------------------------------------------------------------
    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_result = w_out_valid ? r_mem_result[r_rptr] : '0;
    assign bus.out_op     = w_out_valid ? r_mem_op[r_rptr]     : 3'd0;
    assign bus.out_tag    = w_out_valid ? r_mem_tag[r_rptr]    : '0;
    assign bus.out_zero   = w_out_valid ? r_mem_zero[r_rptr]   : 1'b0;
    assign bus.out_neg    = w_out_valid ? r_mem_neg[r_rptr]    : 1'b0;

`ifdef ALU_RESULT_STAGE_PERF_EN
    // ------------------------------------------------------------------
    // Saturating event counters; flush leaves them untouched
    // ------------------------------------------------------------------
    logic [31:0] r_perf_accepted;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_accepted <= '0;
            r_perf_stall    <= '0;
        end else begin
            if (w_push && !flush && (r_perf_accepted != 32'hFFFF_FFFF)) begin
                r_perf_accepted <= r_perf_accepted + 32'd1;
            end
            if (w_out_valid && !bus.out_ready && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_accepted = r_perf_accepted;
    assign perf_stall    = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_result_stage
// Description : Self-checking bench for alu_result_stage against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_stage;
    localparam int N     = 32;
    localparam int DEPTH = 2;
    localparam int TAG_W = 5;
    localparam int VW    = 2 + N + 3 + TAG_W + 2;
    localparam longint SAT = 64'hFFFF_FFFF;

    typedef logic [VW-1:0] vec_t;
    typedef struct {
        logic [N-1:0]     res;
        logic [2:0]       op;
        logic [TAG_W-1:0] tag;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    alu_result_stage_if #(.N(N), .TAG_W(TAG_W)) ifc ();

`ifdef ALU_RESULT_STAGE_PERF_EN
    logic [31:0] perf_accepted;
    logic [31:0] perf_stall;
`endif

    alu_result_stage #(.N(N), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (ifc)
`ifdef ALU_RESULT_STAGE_PERF_EN
        ,
        .perf_accepted (perf_accepted),
        .perf_stall    (perf_stall)
`endif
    );

    ent_t   q[$];
    longint m_acc;
    longint m_stall;
    int     n_total;
    int     n_pass;

    function automatic vec_t exp_vec();
        if (q.size() == 0) return {1'b0, 1'b1, {(VW-2){1'b0}}};
        return {1'b1, (q.size() != DEPTH), q[0].res, q[0].op, q[0].tag,
                (q[0].res == '0), q[0].res[N-1]};
    endfunction

    function automatic vec_t dut_vec();
        return {ifc.out_valid, ifc.in_ready, ifc.out_result, ifc.out_op,
                ifc.out_tag, ifc.out_zero, ifc.out_neg};
    endfunction

    task automatic set_in(input logic v, input logic [N-1:0] r,
                          input logic [2:0] op, input logic [TAG_W-1:0] tag);
        ifc.in_valid  = v;
        ifc.in_result = r;
        ifc.in_op     = op;
        ifc.in_tag    = tag;
    endtask

    // Advance one clock, applying the FIFO rules to the queue model.
    task automatic tick();
        bit   push = ifc.in_valid && (q.size() != DEPTH);
        bit   pop  = (q.size() != 0) && ifc.out_ready;
        ent_t e;
        e.res = ifc.in_result;
        e.op  = ifc.in_op;
        e.tag = ifc.in_tag;
        if (rst) begin
            q.delete();
            m_acc   = 0;
            m_stall = 0;
        end else begin
            if (q.size() != 0 && !ifc.out_ready && m_stall < SAT) m_stall++;
            if (flush) begin
                q.delete();
            end else begin
                if (push && m_acc < SAT) m_acc++;
                if (pop) void'(q.pop_front());
                if (push) q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        ifc.out_ready = 1'b0;
        set_in(1'b1, $urandom, 3'd2, 5'd9);
        tick();
        tick();
        n_total++;
        if (dut_vec() !== {1'b0, 1'b1, {(VW-2){1'b0}}})
            $display("FAIL reset_outputs got=%h exp=%h", dut_vec(), {1'b0, 1'b1, {(VW-2){1'b0}}});
        else n_pass++;
        rst = 1'b0;
        set_in(1'b0, '0, 3'd0, '0);
        tick();
        n_total++;
        if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1)
            $display("FAIL reset_empty got valid=%b ready=%b exp valid=0 ready=1", ifc.out_valid, ifc.in_ready);
        else n_pass++;
    endtask

    task automatic test_single();
        ifc.out_ready = 1'b1;
        set_in(1'b1, 32'h0000_0000, 3'd1, 5'd3);
        n_total++;
        if (dut_vec() !== exp_vec()) $display("FAIL single_pre got=%h exp=%h", dut_vec(), exp_vec());
        else n_pass++;
        tick();
        set_in(1'b0, '0, 3'd0, '0);
        n_total++;
        if (ifc.out_valid !== 1'b1 || ifc.out_zero !== 1'b1 || ifc.out_neg !== 1'b0 || ifc.out_tag !== 5'd3)
            $display("FAIL single_head got v=%b z=%b n=%b tag=%0d exp v=1 z=1 n=0 tag=3",
                     ifc.out_valid, ifc.out_zero, ifc.out_neg, ifc.out_tag);
        else n_pass++;
        n_total++;
        if (dut_vec() !== exp_vec()) $display("FAIL single_model got=%h exp=%h", dut_vec(), exp_vec());
        else n_pass++;
        tick();
        n_total++;
        if (ifc.out_valid !== 1'b0) $display("FAIL single_drain got valid=%b exp 0", ifc.out_valid);
        else n_pass++;
    endtask

    task automatic test_fill();
        ifc.out_ready = 1'b0;
        set_in(1'b1, 32'h8000_0001, 3'd0, 5'd1);
        tick();
        set_in(1'b1, 32'h0000_0005, 3'd0, 5'd2);
        tick();
        n_total++;
        if (ifc.in_ready !== 1'b0) $display("FAIL fill_ready got=%b exp=0", ifc.in_ready);
        else n_pass++;
        set_in(1'b1, 32'h0000_dead, 3'd0, 5'd9);
        tick();
        n_total++;
        if (ifc.out_neg !== 1'b1 || ifc.out_tag !== 5'd1 || dut_vec() !== exp_vec())
            $display("FAIL fill_refuse got=%h exp=%h", dut_vec(), exp_vec());
        else n_pass++;
        set_in(1'b0, '0, 3'd0, '0);
        ifc.out_ready = 1'b1;
        tick();
        n_total++;
        if (ifc.out_tag !== 5'd2 || dut_vec() !== exp_vec())
            $display("FAIL fill_order got=%h exp=%h", dut_vec(), exp_vec());
        else n_pass++;
        tick();
        n_total++;
        if (dut_vec() !== exp_vec()) $display("FAIL fill_drain got=%h exp=%h", dut_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_stream();
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, $urandom, 3'($urandom_range(0, 7)), TAG_W'(i));
            tick();
            n_total++;
            if (ifc.out_tag !== TAG_W'(i) || ifc.in_ready !== 1'b1 || dut_vec() !== exp_vec())
                $display("FAIL stream_%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            else n_pass++;
        end
        set_in(1'b0, '0, 3'd0, '0);
        tick();
        n_total++;
        if (dut_vec() !== exp_vec()) $display("FAIL stream_end got=%h exp=%h", dut_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_flush();
        ifc.out_ready = 1'b0;
        set_in(1'b1, 32'h1111_0000, 3'd3, 5'd4);
        tick();
        set_in(1'b1, 32'h2222_0000, 3'd4, 5'd5);
        tick();
        set_in(1'b1, 32'h7777_0000, 3'd5, 5'd7);
        ifc.out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_in(1'b0, '0, 3'd0, '0);
        n_total++;
        if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1 || dut_vec() !== exp_vec())
            $display("FAIL flush_empty got=%h exp=%h", dut_vec(), exp_vec());
        else n_pass++;
        for (int i = 0; i < 3; i++) tick();
        n_total++;
        if (ifc.out_valid !== 1'b0) $display("FAIL flush_no_tag7 got valid=%b tag=%0d exp valid=0", ifc.out_valid, ifc.out_tag);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] r;
            case ($urandom_range(0, 3))
                0:       r = '0;
                1:       r = {1'b1, (N-1)'($urandom)};
                default: r = $urandom;
            endcase
            if (!(ifc.in_valid && !ifc.in_ready))
                set_in(1'($urandom_range(0, 1)), r, 3'($urandom_range(0, 7)), TAG_W'($urandom));
            ifc.out_ready = 1'($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 24) == 0);
            rst   = ($urandom_range(0, 59) == 0);
            tick();
            n_total++;
            if (dut_vec() !== exp_vec()) begin
                errs++;
                if (errs < 10) $display("FAIL random_%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end else n_pass++;
        end
        rst = 1'b0;
        flush = 1'b0;
        set_in(1'b0, '0, 3'd0, '0);
    endtask

`ifdef ALU_RESULT_STAGE_PERF_EN
    task automatic test_perf();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, $urandom, 3'd0, TAG_W'(i));
            tick();
        end
        set_in(1'b0, '0, 3'd0, '0);
        ifc.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_total++;
        if (perf_accepted !== 32'd3 || perf_accepted !== m_acc[31:0])
            $display("FAIL perf_accepted got=%0d exp=3", perf_accepted);
        else n_pass++;
        n_total++;
        if (perf_stall !== 32'd4 || perf_stall !== m_stall[31:0])
            $display("FAIL perf_stall got=%0d exp=4", perf_stall);
        else n_pass++;
        dut.r_perf_stall = 32'hFFFF_FFFF;
        m_stall = SAT;
        tick();
        tick();
        n_total++;
        if (perf_stall !== 32'hFFFF_FFFF) $display("FAIL perf_sat got=%h exp=ffffffff", perf_stall);
        else n_pass++;
        ifc.out_ready = 1'b1;
        tick();
    endtask
`endif

    initial begin
        n_total = 0;
        n_pass  = 0;
        m_acc   = 0;
        m_stall = 0;
        rst = 1'b1;
        flush = 1'b0;
        ifc.out_ready = 1'b0;
        set_in(1'b0, '0, 3'd0, '0);
        #1;
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_flush();
        test_random();
`ifdef ALU_RESULT_STAGE_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered writeback stage directly downstream of the combinational ALU.
- Captures RESULT with its op code and a transaction tag, derives status flags, and buffers entries in a small FIFO.
- Presents entries to the register-file/forwarding logic over a valid/ready handshake, decoupling ALU issue from writeback back-pressure.

Parameters:
- N, 32, data width; must match the ALU's N.
- DEPTH, 2, FIFO entries; power of two, >= 2.
- TAG_W, 5, tag width (destination register index).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  upstream presents a valid ALU result.
- in_ready  out  1  stage can accept an entry this cycle.
- in_result  in  N  ALU RESULT.
- in_op  in  3  op code that produced in_result, encoded as ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5.
- in_tag  in  TAG_W  destination tag.
- flush  in  1  synchronous discard of all buffered entries.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes the head entry.
- out_result  out  N  head result.
- out_op  out  3  head op code.
- out_tag  out  TAG_W  head tag.
- out_zero  out  1  head result == 0.
- out_neg  out  1  head result[N-1].

Behaviour:
- Clock and reset: one clock `clk`. `rst` is synchronous and active-high; it acts only on a rising edge of `clk`.
- Reset: count=0, read/write pointers=0, out_valid=0, in_ready=1. out_result, out_op, out_tag, out_zero and out_neg all read 0 while the FIFO is empty.
- Storage: DEPTH-entry circular FIFO. Each entry holds {result, op, tag, zero, neg}.
  - Flags are computed at push time from in_result: zero = (in_result == 0), neg = in_result[N-1].
- Push: occurs when in_valid && in_ready. The entry is written at wptr, and wptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
- Pop: occurs when out_valid && out_ready. rptr increments modulo DEPTH.
- in_ready = (count != DEPTH), decoded combinationally from registered count. It has no combinational path from out_ready: a full FIFO does not accept an entry even if a pop happens in the same cycle.
- out_valid = (count != 0). The out_* signals are driven from the entry at rptr, or 0 when empty.
- Latency: an entry pushed into an empty FIFO appears on out_* in the next cycle. Throughput is 1 entry/cycle with simultaneous push and pop.
- Simultaneous push and pop (0 < count < DEPTH): count unchanged, both pointers advance.
- Ordering: strict FIFO order. Tags are carried opaquely, with no reordering and no deduplication.
- Upstream protocol: while in_valid=1 && in_ready=0, upstream holds in_valid, in_result, in_op and in_tag stable. The stage does not check this.
- Downstream protocol: out_* are stable while out_valid=1 && out_ready=0.
- Flush: next state is count=0 and both pointers=0. Any push or pop in the same cycle is ignored. in_ready=1 in the following cycle.
- Reset mid-operation: identical to flush. Buffered entries are lost, and no partial entry is ever presented.
- in_op values 6 and 7 are stored and forwarded unchanged. Flags are computed as normal.

Optional Feature:
- Macro: ALU_RESULT_STAGE_PERF_EN.
- When defined, the block adds:
  - output perf_accepted (32 bits): count of pushes.
  - output perf_stall (32 bits): count of cycles with out_valid && !out_ready.
  - Both counters saturate at 32'hFFFF_FFFF and clear on rst. flush does not clear them.
- When undefined, these ports and the counters are absent. All other behaviour is identical.

Test Plan:
- Reset/empty: assert rst for 2 cycles with in_valid=1. Required: out_valid=0, in_ready=1, all out_* = 0, no entry stored after rst is released.
- Single pass: push in_result=32'h0000_0000, op=1, tag=3 with out_ready=1. Required: next cycle out_valid=1, out_zero=1, out_neg=0, out_tag=3; FIFO empty the cycle after.
- Fill/back-pressure: out_ready=0, push 32'h8000_0001 (tag 1) then 32'h5 (tag 2). Required: in_ready=0 after the 2nd push and a 3rd push is refused; head shows out_neg=1. Release out_ready: tags emerge in order 1, 2.
- Streaming with wrap: push 10 entries tagged 0..9, one per cycle, with out_ready=1. Required: pointers wrap, outputs are tags 0..9 in order at 1/cycle with 1-cycle latency, count never exceeds 1.
- Flush: two entries buffered, assert flush while in_valid=1 (tag 7). Required: next cycle out_valid=0 and in_ready=1; tag 7 is never output.
- Perf (macro defined): 3 pushes, out_ready=0 for 4 cycles with out_valid=1. Required: perf_accepted=3, perf_stall=4. Preload perf_stall to the saturation value: it stays at 32'hFFFF_FFFF.
